// File: rtl/sseg4_scheduler.sv
// sseg4_scheduler: digit scan generator and two-requester display arbiter.
// Ownership, data and format changes are applied only on frame boundaries
// so the seven-segment driver never shows a torn frame.
module sseg4_scheduler #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned HOLD_FRAMES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req,
   input  logic [11:0] val0,
   input  logic [11:0] val1,
   input  logic [1:0]  hex_dec_in,
   input  logic [1:0]  sign_in,
   output logic [1:0]  gnt,
   output logic [15:0] data,
   output logic        hex_dec,
   output logic        sign,
   output logic [1:0]  digit_sel,
   output logic        frame_done
);

   localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         digit_sel_q, digit_sel_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic               last_q, last_d;
   logic [1:0]         gnt_q, gnt_d;
   logic [15:0]        data_q, data_d;
   logic               hex_dec_q, hex_dec_d;
   logic               sign_q, sign_d;
   logic               frame_done_q, frame_done_d;

   logic tick;
   logic frame_end;
   logic owner;
   logic other;
   logic first;
   logic sel;

   assign tick      = (cnt_q == CNT_MAX);
   assign frame_end = tick && (digit_sel_q == 2'd3);

   // Prescaler and digit scan counter.
   always_comb begin
      cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
      digit_sel_d = tick ? digit_sel_q + 2'd1 : digit_sel_q;
   end

   // Owner arbitration and frame-boundary latching of the display payload.
   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      last_d       = last_q;
      gnt_d        = gnt_q;
      data_d       = data_q;
      hex_dec_d    = hex_dec_q;
      sign_d       = sign_q;
      frame_done_d = frame_end;
      owner        = (state_q == OWN1);
      other        = ~owner;
      first        = ~last_q;
      sel          = 1'b0;

      if (frame_end) begin
         if ((state_q != IDLE) && req[owner] &&
             ((hold_cnt_q < HOLD_MAX) || !req[other])) begin
            // Keep the current owner; hold count saturates.
            if (hold_cnt_q < HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end else if (|req) begin
            // Round-robin starting from the requester after the last owner.
            if (req[first]) begin
               state_d = first ? OWN1 : OWN0;
               last_d  = first;
            end else begin
               state_d = last_q ? OWN1 : OWN0;
               last_d  = last_q;
            end
            hold_cnt_d = '0;
         end else begin
            state_d    = IDLE;
            hold_cnt_d = '0;
         end

         sel = (state_d == OWN1);
         case (state_d)
            OWN0:    gnt_d = 2'b01;
            OWN1:    gnt_d = 2'b10;
            default: gnt_d = 2'b00;
         endcase
         if (state_d == IDLE) begin
            data_d    = 16'h0000;
            hex_dec_d = 1'b0;
            sign_d    = 1'b0;
         end else begin
            data_d    = {4'b0000, (sel ? val1 : val0)};
            hex_dec_d = hex_dec_in[sel];
            sign_d    = sign_in[sel];
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         digit_sel_q  <= 2'd0;
         hold_cnt_q   <= '0;
         last_q       <= 1'b1;
         gnt_q        <= 2'b00;
         data_q       <= 16'h0000;
         hex_dec_q    <= 1'b0;
         sign_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         digit_sel_q  <= digit_sel_d;
         hold_cnt_q   <= hold_cnt_d;
         last_q       <= last_d;
         gnt_q        <= gnt_d;
         data_q       <= data_d;
         hex_dec_q    <= hex_dec_d;
         sign_q       <= sign_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign gnt        = gnt_q;
   assign data       = data_q;
   assign hex_dec    = hex_dec_q;
   assign sign       = sign_q;
   assign digit_sel  = digit_sel_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg4_scheduler.sv
// tb_sseg4_scheduler: directed scenarios with a frame-result scoreboard.
module tb_sseg4_scheduler;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [11:0] val0;
   logic [11:0] val1;
   logic [1:0]  hex_dec_in;
   logic [1:0]  sign_in;
   logic [1:0]  gnt;
   logic [15:0] data;
   logic        hex_dec;
   logic        sign;
   logic [1:0]  digit_sel;
   logic        frame_done;

   typedef struct packed {
      logic [1:0]  gnt;
      logic [15:0] data;
      logic        hex_dec;
      logic        sign;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   sseg4_scheduler #(.REFRESH_DIV(4), .HOLD_FRAMES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .val0       (val0),
      .val1       (val1),
      .hex_dec_in (hex_dec_in),
      .sign_in    (sign_in),
      .gnt        (gnt),
      .data       (data),
      .hex_dec    (hex_dec),
      .sign       (sign),
      .digit_sel  (digit_sel),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic push_exp(input logic [1:0] g, input logic [15:0] d, input logic h, input logic s);
      exp_t e;
      e.gnt = g; e.data = d; e.hex_dec = h; e.sign = s;
      exp_q.push_back(e);
   endtask

   // Wait (bounded) for frame_done sampled at a negedge; returns cycles waited.
   task automatic wait_fd(input string tag, output int cycles);
      bit seen;
      seen   = 1'b0;
      cycles = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         cycles++;
         if (frame_done === 1'b1) seen = 1'b1;
      end
      chk({tag, "_timeout"}, 32'(seen), 32'd1);
   endtask

   // Pop the oldest expected frame result and compare with the DUT outputs.
   task automatic check_frame(input string tag);
      int   c;
      exp_t e;
      exp_t o;
      wait_fd(tag, c);
      if (exp_q.size() == 0) begin
         chk({tag, "_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         o.gnt = gnt; o.data = data; o.hex_dec = hex_dec; o.sign = sign;
         chk(tag, 32'(o), 32'(e));
      end
   endtask

   initial begin
      int c;
      rst_n      = 1'b0;
      req        = 2'b00;
      val0       = 12'h000;
      val1       = 12'h000;
      hex_dec_in = 2'b00;
      sign_in    = 2'b00;

      // Reset state.
      idle_cycles(2);
      chk("reset_state", {11'd0, frame_done, digit_sel, gnt, hex_dec, sign, data},
          32'd0);

      // Scan after reset: digit every 4 cycles, frame_done every 16.
      rst_n = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         chk($sformatf("scan_%0d", k), {11'd0, frame_done, digit_sel, gnt, data},
             {11'd0, 1'((k % 16) == 0), 2'((k / 4) % 4), 2'b00, 16'h0000});
      end

      // Single requester arrives mid-frame.
      idle_cycles(8);
      req = 2'b01; val0 = 12'hABC; hex_dec_in = 2'b01;
      push_exp(2'b01, 16'h0ABC, 1'b1, 1'b0);
      check_frame("single_grant");

      // Mid-frame value change is deferred to the frame end.
      idle_cycles(4);
      val0 = 12'h123;
      idle_cycles(1);
      chk("single_frozen", 32'(data), 32'h0ABC);
      push_exp(2'b01, 16'h0123, 1'b1, 1'b0);
      check_frame("single_update");

      // Owner drops mid-frame: grant held until frame end.
      idle_cycles(6);
      req = 2'b00;
      idle_cycles(2);
      chk("drop_hold_gnt", {14'd0, gnt, data}, {14'd0, 2'b01, 16'h0123});
      push_exp(2'b00, 16'h0000, 1'b0, 1'b0);
      check_frame("drop_idle");

      // Contention from IDLE: last owner was 0, so requester 1 starts.
      idle_cycles(4);
      req = 2'b11; val1 = 12'h456; hex_dec_in = 2'b01; sign_in = 2'b10;
      push_exp(2'b10, 16'h0456, 1'b0, 1'b1);
      push_exp(2'b10, 16'h0456, 1'b0, 1'b1);
      push_exp(2'b01, 16'h0123, 1'b1, 1'b0);
      push_exp(2'b01, 16'h0123, 1'b1, 1'b0);
      push_exp(2'b10, 16'h0456, 1'b0, 1'b1);
      push_exp(2'b10, 16'h0456, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) check_frame($sformatf("contend_%0d", k));

      // Uncontested hold by requester 1 for 10 frames.
      idle_cycles(3);
      req = 2'b10;
      for (int k = 0; k < 10; k++) begin
         val1 = 12'(256 + k);
         push_exp(2'b10, 16'(256 + k), 1'b0, 1'b1);
         check_frame($sformatf("uncontested_%0d", k));
      end

      // Reset mid-operation at digit 2 while requester 1 owns.
      idle_cycles(8);
      chk("pre_reset", {28'd0, digit_sel, gnt}, {28'd0, 2'd2, 2'b10});
      #2;
      rst_n = 1'b0;
      req   = 2'b11;
      #1;
      chk("async_reset", {11'd0, frame_done, digit_sel, gnt, hex_dec, sign, data},
          32'd0);
      idle_cycles(2);
      rst_n = 1'b1;
      push_exp(2'b01, 16'h0123, 1'b1, 1'b0);
      wait_fd("post_reset_fd", c);
      chk("post_reset_latency", 32'(c), 32'd16);
      begin
         exp_t e;
         e = exp_q.pop_front();
         chk("post_reset_tie", {12'd0, gnt, data, hex_dec, sign}, 32'(e));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
